// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the seven-segment display
//                path: controller FSM states, display-symbol encoding and
//                active-low segment codes ({dp,g,f,e,d,c,b,a}).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Width of the binary input and of the 10-digit BCD accumulator
    localparam int BIN_W      = 32;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One display position; numeric symbols equal their BCD value so a
    // BCD nibble can be cast straight into this type.
    typedef enum logic [3:0] {
        SYM_0     = 4'd0,
        SYM_1     = 4'd1,
        SYM_2     = 4'd2,
        SYM_3     = 4'd3,
        SYM_4     = 4'd4,
        SYM_5     = 4'd5,
        SYM_6     = 4'd6,
        SYM_7     = 4'd7,
        SYM_8     = 4'd8,
        SYM_9     = 4'd9,
        SYM_MINUS = 4'd10,
        SYM_E     = 4'd11,
        SYM_R     = 4'd12,
        SYM_BLANK = 4'd13
    } sym_t;

    // Active-low segment patterns, dp always off
    localparam logic [7:0] CODE_0     = 8'hC0;
    localparam logic [7:0] CODE_1     = 8'hF9;
    localparam logic [7:0] CODE_2     = 8'hA4;
    localparam logic [7:0] CODE_3     = 8'hB0;
    localparam logic [7:0] CODE_4     = 8'h99;
    localparam logic [7:0] CODE_5     = 8'h92;
    localparam logic [7:0] CODE_6     = 8'h82;
    localparam logic [7:0] CODE_7     = 8'hF8;
    localparam logic [7:0] CODE_8     = 8'h80;
    localparam logic [7:0] CODE_9     = 8'h90;
    localparam logic [7:0] CODE_MINUS = 8'hBF;
    localparam logic [7:0] CODE_E     = 8'h86;
    localparam logic [7:0] CODE_R     = 8'hAF;
    localparam logic [7:0] CODE_BLANK = 8'hFF;

    // Map a display symbol to its segment pattern
    function automatic logic [7:0] seg_code(input sym_t sym);
        logic [7:0] code;
        case (sym)
            SYM_0:     code = CODE_0;
            SYM_1:     code = CODE_1;
            SYM_2:     code = CODE_2;
            SYM_3:     code = CODE_3;
            SYM_4:     code = CODE_4;
            SYM_5:     code = CODE_5;
            SYM_6:     code = CODE_6;
            SYM_7:     code = CODE_7;
            SYM_8:     code = CODE_8;
            SYM_9:     code = CODE_9;
            SYM_MINUS: code = CODE_MINUS;
            SYM_E:     code = CODE_E;
            SYM_R:     code = CODE_R;
            default:   code = CODE_BLANK;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter. A start
//                pulse loads the binary operand and clears the accumulator;
//                one add-3/shift step is then performed per clock for 32
//                clocks.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - load bin and begin a conversion
//                bin[31:0]  - unsigned operand
//                done       - high during the cycle of the final shift; bcd
//                             holds the finished result from the next cycle
//                bcd[39:0]  - 10-digit BCD accumulator, digit 0 in [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [4:0]       r_cnt;
    logic             r_active;
    logic [BCD_W-1:0] w_adj;

    // Add-3 correction for every nibble that would overflow past 9 on shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt          <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_active <= 1'b0;
            end
        end
    end

    assign done = r_active && (r_cnt == 5'd31);
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg7_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display
//  Description : Multiplexed seven-segment display driver. Captures a signed
//                32-bit value, converts its magnitude to BCD, applies
//                leading-zero suppression and minus-sign placement (or an
//                "Err" image when the value does not fit) and scans the
//                digits with active-low anodes and segments.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load_i          - capture value_i when idle
//                value_i[31:0]   - signed value to show
//                busy_o          - conversion in progress, loads ignored
//                ovf_o           - last committed value did not fit
//                an_o[N-1:0]     - active-low digit enables, bit 0 rightmost
//                seg_o[7:0]      - active-low {dp,g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [BIN_W-1:0]      value_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [7:0]            seg_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0]      c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]            c_kmax_pos = 4'(NUM_DIGITS - 1);
    localparam logic [3:0]            c_kmax_neg = 4'(NUM_DIGITS - 2);
    localparam logic [NUM_DIGITS-1:0] c_an_one   = NUM_DIGITS'(1);

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_sign;
    logic             r_busy;
    logic             r_ovf;
    sym_t             r_image [NUM_DIGITS];

    logic             w_start;
    logic [BIN_W-1:0] w_mag;
    logic             w_done;
    logic [BCD_W-1:0] w_bcd;
    logic [3:0]       w_k;
    logic             w_fit;
    sym_t             w_commit_image [NUM_DIGITS];
    sym_t             w_image_next   [NUM_DIGITS];

    assign w_start = load_i && (r_state == ST_IDLE);

    // Two's-complement magnitude; -2^31 maps to 2^31 in the unsigned domain
    assign w_mag = value_i[BIN_W-1] ? (~value_i + 32'd1) : value_i;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_mag),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // ------------------------------------------------------------------
    // Fit check and image composition from the finished BCD value
    // ------------------------------------------------------------------
    always_comb begin
        w_k = 4'd0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) begin
                w_k = 4'(i);
            end
        end
        // A negative value needs one extra position for the minus sign
        w_fit = r_sign ? (w_k <= c_kmax_neg) : (w_k <= c_kmax_pos);
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_commit_image[i] = SYM_BLANK;
            if (w_fit) begin
                if (4'(i) <= w_k) begin
                    w_commit_image[i] = sym_t'(w_bcd[4*i +: 4]);
                end else if (r_sign && (4'(i) == (w_k + 4'd1))) begin
                    w_commit_image[i] = SYM_MINUS;
                end
            end else begin
                if (i == 0 || i == 1) begin
                    w_commit_image[i] = SYM_R;
                end else if (i == 2) begin
                    w_commit_image[i] = SYM_E;
                end
            end
        end
    end

    // The scan register samples the image that will exist after this edge,
    // so a commit reaches seg_o on the very next cycle.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_image_next[i] = (r_state == ST_COMMIT) ? w_commit_image[i]
                                                     : r_image[i];
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_image[i] <= (i == 0) ? SYM_0 : SYM_BLANK;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_i) begin
                        r_sign  <= value_i[BIN_W-1];
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_done) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_image[i] <= w_commit_image[i];
                    end
                    r_ovf   <= ~w_fit;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = r_busy;
    assign ovf_o  = r_ovf;

    // ------------------------------------------------------------------
    // Digit scan, independent of the controller
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]       r_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_an  <= '1;
            r_seg <= CODE_BLANK;
        end else begin
            r_an  <= ~(c_an_one << r_idx);
            r_seg <= seg_code(w_image_next[r_idx]);
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display
//  Description : Directed self-checking bench for seg7_display with
//                NUM_DIGITS=8 and SCAN_DIV=4 (32-cycle scan frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display;

    localparam int NUM_DIGITS = 8;
    localparam int SCAN_DIV   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_i = 1'b0;
    logic [31:0] value_i = 32'd0;
    logic        busy_o;
    logic        ovf_o;
    logic [7:0]  an_o;
    logic [7:0]  seg_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] frame [8];
    logic       seen  [8];
    logic [7:0] exp_f [8];
    int         cyc;

    seg7_display #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_i),
        .value_i (value_i),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o),
        .an_o    (an_o),
        .seg_o   (seg_o)
    );

    always #5 clk = ~clk;

    // Record the segment pattern seen under each anode over > one frame
    task automatic capture_frame();
        for (int d = 0; d < 8; d++) begin
            frame[d] = 8'h00;
            seen[d]  = 1'b0;
        end
        repeat (40) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                if (an_o == ~(8'h01 << d)) begin
                    frame[d] = seg_o;
                    seen[d]  = 1'b1;
                end
            end
        end
    endtask

    // One-cycle load strobe; returns in the middle of cycle T+1
    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        load_i  = 1'b1;
        value_i = v;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    // Bounded wait for busy_o to drop; cycles reports how long it took
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_o && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an_o !== 8'hFF || seg_o !== 8'hFF || busy_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: an=%h seg=%h busy=%b ovf=%b required an=FF seg=FF busy=0 ovf=0",
                     an_o, seg_o, busy_o, ovf_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (an_o !== 8'hFE || seg_o !== 8'hC0) begin
            n_fail++;
            $display("FAIL first_scan: an=%h seg=%h required an=FE seg=C0", an_o, seg_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an_o !== 8'hFE) begin
            n_fail++;
            $display("FAIL scan_hold_digit0: an=%h required FE", an_o);
        end
        @(negedge clk);
        n_cmp++;
        if (an_o !== 8'hFD) begin
            n_fail++;
            $display("FAIL scan_step_digit1: an=%h required FD", an_o);
        end
        capture_frame();
        exp_f = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL reset_image digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b ovf=%b required 0 0", busy_o, ovf_o);
        end
    endtask

    task automatic test_positive();
        do_load(32'd1234);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: busy=%b required 1", busy_o);
        end
        wait_idle(cyc);
        n_cmp++;
        if (cyc != 33) begin
            n_fail++;
            $display("FAIL busy_length: %0d cycles required 33", cyc);
        end
        capture_frame();
        exp_f = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL val1234 digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        n_cmp++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL val1234_ovf: ovf=%b required 0", ovf_o);
        end
    endtask

    task automatic test_negative();
        do_load(-32'sd56);
        wait_idle(cyc);
        capture_frame();
        exp_f = '{8'h82, 8'h92, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL neg56 digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
    endtask

    task automatic test_width_limits();
        // Largest negative that fits: seven nines plus the sign
        do_load(-32'sd9999999);
        wait_idle(cyc);
        capture_frame();
        exp_f = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'hBF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL neg9999999 digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        n_cmp++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL neg9999999_ovf: ovf=%b required 0", ovf_o);
        end
        // One more digit with a sign no longer fits
        do_load(-32'sd10000000);
        wait_idle(cyc);
        capture_frame();
        exp_f = '{8'hAF, 8'hAF, 8'h86, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL neg10000000 digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        n_cmp++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL neg10000000_ovf: ovf=%b required 1", ovf_o);
        end
        // Largest positive that fits uses all eight digits
        do_load(32'd99999999);
        wait_idle(cyc);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== 8'h90) begin
                n_fail++;
                $display("FAIL pos99999999 digit%0d: got %h (seen=%0d) required 90", d, frame[d], seen[d]);
            end
        end
        n_cmp++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pos99999999_ovf: ovf=%b required 0", ovf_o);
        end
    endtask

    task automatic test_busy_drop();
        do_load(32'd7);
        repeat (9) @(negedge clk);
        load_i  = 1'b1;
        value_i = 32'd5;
        @(negedge clk);
        load_i  = 1'b0;
        wait_idle(cyc);
        n_cmp++;
        if (cyc != 23) begin
            n_fail++;
            $display("FAIL drop_busy_length: %0d cycles required 23", cyc);
        end
        capture_frame();
        exp_f = '{8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL drop_val7 digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_not_queued: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_overflow_extremes();
        do_load(32'd100000000);
        wait_idle(cyc);
        n_cmp++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pos100000000_ovf: ovf=%b required 1", ovf_o);
        end
        capture_frame();
        exp_f = '{8'hAF, 8'hAF, 8'h86, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL pos100000000 digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        do_load(32'h8000_0000);
        wait_idle(cyc);
        n_cmp++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL min_int_ovf: ovf=%b required 1", ovf_o);
        end
    endtask

    task automatic test_reset_mid_conv();
        do_load(32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || ovf_o !== 1'b0 || an_o !== 8'hFF || seg_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL midconv_reset: busy=%b ovf=%b an=%h seg=%h required 0 0 FF FF",
                     busy_o, ovf_o, an_o, seg_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (an_o !== 8'hFE || seg_o !== 8'hC0) begin
            n_fail++;
            $display("FAIL midconv_restart: an=%h seg=%h required FE C0", an_o, seg_o);
        end
        capture_frame();
        exp_f = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int d = 0; d < 8; d++) begin
            n_cmp++;
            if (!seen[d] || frame[d] !== exp_f[d]) begin
                n_fail++;
                $display("FAIL midconv_image digit%0d: got %h (seen=%0d) required %h", d, frame[d], seen[d], exp_f[d]);
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midconv_flags: busy=%b ovf=%b required 0 0", busy_o, ovf_o);
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_width_limits();
        test_busy_drop();
        test_overflow_extremes();
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_display.md
Name: seg7_display

Overview:
- Output-side counterpart of the debounced button front end: it drives the multiplexed 8-digit seven-segment display of the calculator.
- Accepts a signed 32-bit result with a load strobe.
- Converts the magnitude to BCD sequentially with a double-dabble algorithm, one shift per cycle.
- Applies leading-zero suppression, places the minus sign and scans the digits with active-low anode and segment outputs.

Parameters:
- NUM_DIGITS, 8: physical digits; legal range 2..8.
- SCAN_DIV, 100000: clk cycles each digit stays lit; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- load_i  in  1  one-cycle strobe; value_i is captured when the FSM is in IDLE
- value_i  in  32  signed two's-complement value to show
- busy_o  out  1  conversion in progress; load_i is ignored while high
- ovf_o  out  1  the last committed value did not fit on the display
- an_o  out  NUM_DIGITS  digit enables, active-low; bit i is digit i, digit 0 is rightmost
- seg_o  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp is always 1

Behaviour:
- Reset values: busy_o=0, ovf_o=0, an_o=all 1, seg_o=8'hFF.
- State after reset: FSM=IDLE, scan index=0, scan counter=0, display image = "0" (digit 0 shows 0, all other digits blank, sign off).
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - load_i=1 at cycle T: capture sign = value_i[31] and mag = |value_i| as 32-bit unsigned (-2^31 gives 2^31).
  - Clear the 40-bit BCD accumulator (10 digits) and the bit counter; go to CONV.
- CONV:
  - Cycles T+1..T+32, one double-dabble step per cycle.
  - Each step adds 3 to every BCD nibble >=5, then shifts {bcd,mag} left by 1.
  - After 32 steps, go to COMMIT.
- COMMIT (cycle T+33):
  - Compute fit. Let k = index of the most significant nonzero BCD digit (k=0 if the value is zero).
  - The value fits iff k <= NUM_DIGITS-1 when sign=0, and k <= NUM_DIGITS-2 when sign=1.
  - Fit: the display image takes digits 0..k; digits above k are blank; if sign=1, digit k+1 shows minus; ovf_o=0.
  - No fit: the image is digit0='r', digit1='r', digit2='E', others blank; ovf_o=1.
  - Go to IDLE.
- Image update is atomic; the new pattern is on the outputs from cycle T+34.
- Negative zero cannot occur, so the sign is never shown for 0.
- busy_o=1 in CONV and COMMIT, i.e. cycles T+1..T+33.
- load_i while busy_o=1 is dropped, not queued.
- ovf_o holds until the next COMMIT.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. At terminal count it wraps and the index increments modulo NUM_DIGITS (NUM_DIGITS-1 goes to 0).
  - Registered outputs: an_o = ~(1<<index); seg_o = pattern of image digit[index].
  - A blank digit drives seg_o=8'hFF with its anode still asserted.
  - The first registered update after reset release gives an_o=~1, seg_o=C0.
- Scan runs independently of the FSM; a COMMIT in mid-digit changes seg_o on the next cycle without disturbing the scan.
- Segment codes (hex):
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Symbols: minus=BF, E=86, r=AF, blank=FF.
- rst mid-conversion: abort to IDLE; busy_o=0; image returns to "0"; ovf_o=0.

Decomposition:
- Package seg7_pkg holds:
  - FSM state enum;
  - the segment code constants above plus CODE_BLANK, CODE_MINUS, CODE_E, CODE_R;
  - a 4-bit display-symbol type (0-9, MINUS, E, R, BLANK).
- Sub-module bin2bcd_seq:
  - Ports: clk, rst, start, 32-bit bin, done, 40-bit bcd.
  - Holds the CONV datapath and bit counter.
- The top level keeps fit check, image, scan and encoding.

Test Plan (SCAN_DIV=4, NUM_DIGITS=8):
- Reset, then one idle cycle -> an_o=FE, seg_o=C0; over the next 28 cycles, digits 1..7 show FF; busy_o=0, ovf_o=0.
- load 1234 at T -> busy_o=1 for T+1..T+33; from T+34, digits 0..3 = 99,B0,A4,F9; digits 4..7 = FF; ovf_o=0.
- load -56 -> digit0=82, digit1=92, digit2=BF, digits 3..7=FF.
- load -9999999 -> digits 0..6 = 90, digit7=BF, ovf_o=0; then load -10000000 -> digits 0..2 = AF,AF,86, rest FF, ovf_o=1; then load 99999999 -> all eight digits 90, ovf_o=0.
- load 7, then load 5 at T+10 while busy -> ignored; display shows only 7 (F8); load 100000000 -> ovf_o=1; load -2147483648 -> ovf_o=1.
- Assert rst at T+15 of a conversion -> busy_o=0 next cycle, image "0", ovf_o=0; scan restarts at digit 0.
